// File: rtl/weight_bank_pkg.sv
// Shared types and constants for the weight store and its LFSR init source.
package weight_bank_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          WEIGHT_W     = 10;

  typedef logic [WEIGHT_W-1:0] weight_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/weight_lfsr.sv
// 16-bit Galois LFSR that steps only while enabled; reusable by any init sweep.
module weight_lfsr
  import weight_bank_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        enable,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (enable) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/weight_bank.sv
// N-lane weight store: self-initialising sweep (random or zero), then wrapping burst reads/writes.
//   state | meaning
//   INIT  | sweep writes one entry per cycle, requests are dropped
//   READY | burst reads/writes serviced, InitReq restarts the sweep
module weight_bank
  import weight_bank_pkg::*;
#(
  parameter int          N     = 10,
  parameter int          W     = 10,
  parameter int          DEPTH = 64,
  parameter int          AW    = $clog2(DEPTH),
  parameter logic [15:0] SEED  = DEFAULT_SEED
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          InitReq,
  input  logic          InitMode,
  input  logic          RdEn,
  input  logic          WrEn,
  input  logic [AW-1:0] Address,
  input  logic [W-1:0]  D [0:N-1],
  output logic [W-1:0]  Q [0:N-1],
  output logic          QValid,
  output logic          Ready,
  output logic          InitDone,
  output logic          Drop
);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [15:0]   lfsr;
  logic [W-1:0]  mem_q [0:DEPTH-1];
  logic [W-1:0]  q_q [0:N-1];
  logic [W-1:0]  q_d [0:N-1];
  logic          qvalid_q, qvalid_d;
  logic          init_done_q, init_done_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] lane_addr [0:N-1];
  logic          in_init, rd_go, wr_go, last_init;

  weight_lfsr #(.SEED(SEED)) u_lfsr (
    .Clock  (Clock),
    .Rst    (Rst),
    .enable (in_init),
    .state  (lfsr)
  );

  assign in_init   = (state_q == INIT);
  assign last_init = in_init && (cnt_q == AW'(DEPTH - 1));
  assign rd_go     = !in_init && RdEn;
  assign wr_go     = !in_init && WrEn;

  always_comb begin
    for (int i = 0; i < N; i++) lane_addr[i] = Address + AW'(i);
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (last_init) state_d = READY;
      end
      READY: begin
        if (InitReq) begin
          state_d = INIT;
          cnt_d   = '0;
          mode_d  = InitMode;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Requests in READY alongside InitReq are still serviced before the sweep starts
  always_comb begin
    q_d         = q_q;
    qvalid_d    = rd_go;
    init_done_d = last_init;
    drop_d      = in_init && (RdEn || WrEn || InitReq);
    if (rd_go) begin
      for (int i = 0; i < N; i++) q_d[i] = mem_q[lane_addr[i]];
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < N; i++) q_q[i] <= '0;
      qvalid_q    <= 1'b0;
      init_done_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      q_q         <= q_d;
      qvalid_q    <= qvalid_d;
      init_done_q <= init_done_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (in_init) begin
      mem_q[cnt_q] <= mode_q ? '0 : lfsr[W-1:0];
    end else if (wr_go) begin
      for (int i = 0; i < N; i++) mem_q[lane_addr[i]] <= D[i];
    end
  end

  assign Q        = q_q;
  assign QValid   = qvalid_q;
  assign Ready    = (state_q == READY);
  assign InitDone = init_done_q;
  assign Drop     = drop_q;

endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank: init sweeps, bursts, wrap, collisions, drops and resets.
module tb_weight_bank;

  localparam int N     = 10;
  localparam int W     = 10;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          Clock = 1'b0;
  logic          Rst = 1'b1;
  logic          InitReq = 1'b0;
  logic          InitMode = 1'b0;
  logic          RdEn = 1'b0;
  logic          WrEn = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [W-1:0]  D [0:N-1];
  logic [W-1:0]  Q [0:N-1];
  logic          QValid, Ready, InitDone, Drop;

  int vectors = 0;
  int miscompares = 0;

  weight_bank #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .Clock    (Clock),
    .Rst      (Rst),
    .InitReq  (InitReq),
    .InitMode (InitMode),
    .RdEn     (RdEn),
    .WrEn     (WrEn),
    .Address  (Address),
    .D        (D),
    .Q        (Q),
    .QValid   (QValid),
    .Ready    (Ready),
    .InitDone (InitDone),
    .Drop     (Drop)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < N; i++) D[i] = '0;
    Rst = 1'b1;
    tick();
    tick();
    vectors++; if (Ready !== 1'b0)    begin miscompares++; $display("FAIL reset_ready: got %b expected 0", Ready); end
    vectors++; if (QValid !== 1'b0)   begin miscompares++; $display("FAIL reset_qvalid: got %b expected 0", QValid); end
    vectors++; if (InitDone !== 1'b0) begin miscompares++; $display("FAIL reset_initdone: got %b expected 0", InitDone); end
    vectors++; if (Drop !== 1'b0)     begin miscompares++; $display("FAIL reset_drop: got %b expected 0", Drop); end
    vectors++; if (Q[0] !== 10'd0)    begin miscompares++; $display("FAIL reset_q0: got %0d expected 0", Q[0]); end
  endtask

  // Releases reset and checks the sweep length plus the random contents.
  task automatic sweep_and_check(input string tag);
    int cyc;
    int bad;
    logic [15:0] s;
    Rst = 1'b0;
    cyc = 0;
    while (Ready !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    vectors++; if (cyc !== 64) begin miscompares++; $display("FAIL %s_latency: got %0d cycles expected 64", tag, cyc); end
    vectors++; if (InitDone !== 1'b1) begin miscompares++; $display("FAIL %s_initdone: got %b expected 1", tag, InitDone); end
    s = 16'hACE1;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (dut.mem_q[k] !== s[W-1:0]) begin
        bad++;
        if (bad == 1) $display("FAIL %s_mem[%0d]: got %0d expected %0d", tag, k, dut.mem_q[k], s[W-1:0]);
      end
      s = ref_step(s);
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL %s_contents: %0d entries differ, expected 0", tag, bad); end
    tick();
    vectors++; if (InitDone !== 1'b0) begin miscompares++; $display("FAIL %s_initdone_pulse: got %b expected 0", tag, InitDone); end
  endtask

  task automatic test_auto_init();
    sweep_and_check("auto_init");
  endtask

  task automatic test_write_read();
    WrEn = 1'b1; Address = 6'd5;
    for (int i = 0; i < N; i++) D[i] = W'(100 + i);
    tick();
    WrEn = 1'b0; RdEn = 1'b1; Address = 6'd5;
    tick();
    RdEn = 1'b0;
    vectors++; if (QValid !== 1'b1) begin miscompares++; $display("FAIL wr_rd_qvalid: got %b expected 1", QValid); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (Q[i] !== W'(100 + i)) begin miscompares++; $display("FAIL wr_rd_q[%0d]: got %0d expected %0d", i, Q[i], 100 + i); end
    end
    tick();
    vectors++; if (QValid !== 1'b0) begin miscompares++; $display("FAIL wr_rd_qvalid_pulse: got %b expected 0", QValid); end
    vectors++; if (Q[9] !== W'(109)) begin miscompares++; $display("FAIL wr_rd_q_hold: got %0d expected 109", Q[9]); end
  endtask

  task automatic test_wrap();
    WrEn = 1'b1; Address = 6'd60;
    for (int i = 0; i < N; i++) D[i] = W'(i);
    tick();
    WrEn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (dut.mem_q[60 + k] !== W'(k)) begin miscompares++; $display("FAIL wrap_mem[%0d]: got %0d expected %0d", 60 + k, dut.mem_q[60 + k], k); end
    end
    for (int k = 0; k < 6; k++) begin
      vectors++; if (dut.mem_q[k] !== W'(k + 4)) begin miscompares++; $display("FAIL wrap_mem[%0d]: got %0d expected %0d", k, dut.mem_q[k], k + 4); end
    end
    RdEn = 1'b1; Address = 6'd60;
    tick();
    RdEn = 1'b0;
    vectors++; if (QValid !== 1'b1) begin miscompares++; $display("FAIL wrap_qvalid: got %b expected 1", QValid); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (Q[i] !== W'(i)) begin miscompares++; $display("FAIL wrap_q[%0d]: got %0d expected %0d", i, Q[i], i); end
    end
  endtask

  task automatic test_simultaneous();
    WrEn = 1'b1; Address = 6'd8;
    for (int i = 0; i < N; i++) D[i] = W'(7 + i);
    tick();
    RdEn = 1'b1; WrEn = 1'b1; Address = 6'd8;
    for (int i = 0; i < N; i++) D[i] = W'(300 + i);
    tick();
    WrEn = 1'b0; RdEn = 1'b0;
    vectors++; if (QValid !== 1'b1) begin miscompares++; $display("FAIL simul_qvalid: got %b expected 1", QValid); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (Q[i] !== W'(7 + i)) begin miscompares++; $display("FAIL simul_old_q[%0d]: got %0d expected %0d", i, Q[i], 7 + i); end
    end
    RdEn = 1'b1;
    tick();
    RdEn = 1'b0;
    for (int i = 0; i < N; i++) begin
      vectors++; if (Q[i] !== W'(300 + i)) begin miscompares++; $display("FAIL simul_new_q[%0d]: got %0d expected %0d", i, Q[i], 300 + i); end
    end
  endtask

  task automatic test_zero_fill_drops();
    int bad_drop;
    int bad_qv;
    int bad;
    logic [AW-1:0] addrs [0:2];
    addrs[0] = 6'd0; addrs[1] = 6'd20; addrs[2] = 6'd54;
    // Read issued together with InitReq is still serviced
    RdEn = 1'b1; Address = 6'd60; InitReq = 1'b1; InitMode = 1'b1;
    tick();
    InitReq = 1'b0; InitMode = 1'b0;
    vectors++; if (QValid !== 1'b1) begin miscompares++; $display("FAIL zf_svc_qvalid: got %b expected 1", QValid); end
    vectors++; if (Drop !== 1'b0)   begin miscompares++; $display("FAIL zf_svc_drop: got %b expected 0", Drop); end
    vectors++; if (Q[9] !== W'(9))  begin miscompares++; $display("FAIL zf_svc_q9: got %0d expected 9", Q[9]); end
    vectors++; if (Ready !== 1'b0)  begin miscompares++; $display("FAIL zf_ready_low: got %b expected 0", Ready); end
    bad_drop = 0;
    bad_qv = 0;
    for (int k = 1; k <= 64; k++) begin
      InitReq = (k == 10);
      tick();
      if (Drop !== 1'b1) bad_drop++;
      if (QValid !== 1'b0) bad_qv++;
      if (k < 64 && Ready !== 1'b0) bad_drop++;
    end
    InitReq = 1'b0; RdEn = 1'b0;
    vectors++; if (bad_drop !== 0) begin miscompares++; $display("FAIL zf_drop_cycles: got %0d bad cycles expected 0", bad_drop); end
    vectors++; if (bad_qv !== 0)   begin miscompares++; $display("FAIL zf_qvalid_cycles: got %0d bad cycles expected 0", bad_qv); end
    vectors++; if (Ready !== 1'b1) begin miscompares++; $display("FAIL zf_ready: got %b expected 1", Ready); end
    vectors++; if (InitDone !== 1'b1) begin miscompares++; $display("FAIL zf_initdone: got %b expected 1", InitDone); end
    tick();
    vectors++; if (Drop !== 1'b0) begin miscompares++; $display("FAIL zf_drop_clear: got %b expected 0", Drop); end
    for (int a = 0; a < 3; a++) begin
      RdEn = 1'b1; Address = addrs[a];
      tick();
      RdEn = 1'b0;
      bad = 0;
      for (int i = 0; i < N; i++) if (Q[i] !== '0) bad++;
      vectors++; if (QValid !== 1'b1 || bad !== 0) begin miscompares++; $display("FAIL zf_read_addr%0d: qvalid %b, %0d nonzero lanes, expected 1 and 0", addrs[a], QValid, bad); end
    end
    bad = 0;
    for (int k = 0; k < DEPTH; k++) if (dut.mem_q[k] !== '0) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL zf_contents: got %0d nonzero entries expected 0", bad); end
  endtask

  task automatic test_reset_mid_read();
    WrEn = 1'b1; Address = 6'd0;
    for (int i = 0; i < N; i++) D[i] = W'(5 + i);
    tick();
    WrEn = 1'b0; RdEn = 1'b1;
    tick();
    RdEn = 1'b0;
    vectors++; if (QValid !== 1'b1 || Q[0] !== W'(5)) begin miscompares++; $display("FAIL mid_read_pre: qvalid %b q0 %0d expected 1 and 5", QValid, Q[0]); end
    Rst = 1'b1;
    #1;
    vectors++; if (QValid !== 1'b0) begin miscompares++; $display("FAIL mid_read_qvalid: got %b expected 0", QValid); end
    vectors++; if (Q[0] !== W'(0))  begin miscompares++; $display("FAIL mid_read_q0: got %0d expected 0", Q[0]); end
    vectors++; if (Ready !== 1'b0)  begin miscompares++; $display("FAIL mid_read_ready: got %b expected 0", Ready); end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int bad;
    Rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (Ready !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL mid_sweep_ready_early: got %0d bad cycles expected 0", bad); end
    Rst = 1'b1;
    #1;
    vectors++; if (Ready !== 1'b0 || QValid !== 1'b0) begin miscompares++; $display("FAIL mid_sweep_outputs: ready %b qvalid %b expected 0 0", Ready, QValid); end
    tick();
    sweep_and_check("resweep");
  endtask

  initial begin
    test_reset();
    test_auto_init();
    test_write_read();
    test_wrap();
    test_simultaneous();
    test_zero_fill_drops();
    test_reset_mid_read();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/weight_bank.md
Name: weight_bank

Overview:
- Parametrised N-lane weight store for the drowsiness-detector neural datapath.
- Holds DEPTH words of W bits each.
- An internal init sequencer fills every entry with LFSR pseudo-random values or with zeros.
- After init, serves N-wide burst reads and writes at any base address, with address wrap-around.
- Sits between the training/update logic and the neuron array; the LFSR is instantiated internally.

Parameters:
- N, 10, lanes per burst (1..DEPTH)
- W, 10, weight width in bits (1..16)
- DEPTH, 64, number of stored words (power of two, >= N)
- AW, $clog2(DEPTH), address width (derived)
- SEED, 16'hACE1, LFSR seed (non-zero)

Ports:
- Clock  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- InitReq  in  1  one-cycle pulse: start an init sweep
- InitMode  in  1  sampled with InitReq: 0 = random fill, 1 = zero fill
- RdEn  in  1  burst read request
- WrEn  in  1  burst write request
- Address  in  AW  burst base address
- D  in  N x W  write data; lane i goes to Address+i
- Q  out  N x W  read data; lane i comes from Address+i
- QValid  out  1  Q valid this cycle
- Ready  out  1  bank accepting RdEn/WrEn
- InitDone  out  1  one-cycle pulse at end of sweep
- Drop  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset values: Q all 0, QValid 0, Ready 0, InitDone 0, Drop 0; FSM in INIT; sweep counter 0; LFSR = SEED; mode = random.
- Memory array is not reset.
- FSM states:
  - INIT: writes one entry per cycle at address cnt. Data is lfsr[W-1:0] in random mode, 0 in zero mode. LFSR advances every INIT cycle. cnt increments each cycle.
  - INIT -> READY when cnt == DEPTH-1 is written, so the sweep takes exactly DEPTH cycles. InitDone pulses in the cycle after the last write, which is also the first cycle Ready=1.
  - READY: Ready=1. InitReq -> INIT with cnt=0 and mode latched from InitMode. The LFSR is not re-seeded, so successive random sweeps differ.
- After reset the FSM sweeps automatically in random mode.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, shifts right.
- Read (READY, RdEn=1):
  - Q[i] = mem[(Address+i) mod DEPTH], registered.
  - QValid=1 exactly one cycle later, for one cycle.
  - Q holds its value when QValid=0.
- Write (READY, WrEn=1): mem[(Address+i) mod DEPTH] <= D[i] for all i, in the same edge.
- RdEn and WrEn in the same cycle with overlapping addresses: the read returns pre-write (old) data and the write completes. Both are accepted.
- Address wrap: all lane addresses are computed modulo DEPTH. No out-of-range access is possible.
- Rejections:
  - RdEn or WrEn while not READY (in INIT): request ignored, memory unchanged, QValid stays 0, Drop pulses for one cycle.
  - InitReq while in INIT: ignored; the sweep continues; Drop pulses.
  - InitReq together with RdEn/WrEn in READY: the RdEn/WrEn is serviced this cycle and INIT starts next cycle. Drop stays 0.
- Reset mid-sweep or mid-read:
  - Outputs return to reset values immediately.
  - Any in-flight QValid is lost.
  - A new automatic random sweep starts from cnt=0 with LFSR=SEED.
  - Partially written contents are overwritten by that sweep.
- Widths: Address+i uses AW-bit truncating addition. D and Q are unpacked arrays [0:N-1] of [W-1:0].

Decomposition:
- Package weight_bank_pkg:
  - state enum {INIT, READY}
  - LFSR tap constant
  - default SEED
  - typedef for the weight word
- Sub-module weight_lfsr:
  - Ports: Clock, Rst, enable, 16-bit state out.
  - Seeded by parameter.
  - Reusable by other init blocks.

Test Plan:
- Auto-init: release Rst, DEPTH=64 -> Ready rises exactly 64 cycles later with a one-cycle InitDone. A backdoor read of mem[0..63] matches a reference-model LFSR from 16'hACE1, low W bits.
- Write/read: WrEn, Address=5, D[i]=100+i -> next cycle RdEn, Address=5 -> QValid one cycle later with Q[i]=100+i.
- Wrap: write N=10 lanes at Address=60, D[i]=i -> mem[60..63]=0..3 and mem[0..5]=4..9; a read at Address=60 returns 0..9.
- Zero fill and drops: InitReq with InitMode=1 -> for 64 cycles RdEn gives Drop=1 and QValid=0; afterwards every read returns all zeros.
- Simultaneous RdEn+WrEn at Address=8 (old value 7, new 300) -> Q[0]=7, and a following read gives 300.
- Reset at cycle 20 of a sweep -> Ready=0 and QValid=0 immediately; a fresh 64-cycle sweep follows with contents identical to the first auto-init.
